// File: rtl/pingpong_frame_buffer_if.sv
// Writer/reader port bundle for pingpong_frame_buffer.
// The master side drives pixels and read requests; the slave side is the buffer.
interface pingpong_frame_buffer_if #(
  parameter int PIX_W = 1,
  parameter int DEPTH = 16384
);
  localparam int WA_W = $clog2(DEPTH);
  localparam int RA_W = WA_W + 1;

  logic             wr_frame_start;
  logic             wr_pix_valid;
  logic [PIX_W-1:0] wr_pix;
  logic             wr_frame_done;
  logic [RA_W-1:0]  rd_addr;
  logic [7:0]       rd_data;
  logic             rd_frame_avail;
  logic [WA_W:0]    rd_frame_len;
  logic             rd_release;
  logic             wr_busy;
  logic             frame_dropped;
  logic             overflow;
  logic [7:0]       drop_count;

  modport master (
    output wr_frame_start, wr_pix_valid, wr_pix, wr_frame_done, rd_addr, rd_release,
    input  rd_data, rd_frame_avail, rd_frame_len, wr_busy, frame_dropped, overflow, drop_count
  );

  modport slave (
    input  wr_frame_start, wr_pix_valid, wr_pix, wr_frame_done, rd_addr, rd_release,
    output rd_data, rd_frame_avail, rd_frame_len, wr_busy, frame_dropped, overflow, drop_count
  );
endinterface

// File: rtl/pingpong_frame_buffer.sv
// Two-bank ping-pong frame buffer: pixels pack LSB-first into 16-bit words, reader sees bytes.
// Define PPBUF_DROP_CNT_EN to build the saturating refused-frame counter (drop_count).
module pingpong_frame_buffer #(
  parameter int PIX_W = 1,
  parameter int DEPTH = 16384
) (
  input logic clk,
  input logic reset,
  pingpong_frame_buffer_if.slave bus
);
  localparam int WA_W  = $clog2(DEPTH);
  localparam int RA_W  = WA_W + 1;
  localparam int PPW   = 16 / PIX_W;
  localparam int IDX_W = $clog2(PPW);
  localparam logic [WA_W:0] DEPTH_CNT = (WA_W+1)'(DEPTH);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bankState_t;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wrState_t;

  logic [15:0]      r_mem [0:2*DEPTH-1];
  bankState_t       r_bankState [2];
  logic [WA_W:0]    r_bankLen [2];
  wrState_t         r_wrState;
  logic             r_wrBank;
  logic [WA_W:0]    r_wordCnt;
  logic [IDX_W-1:0] r_pixIdx;
  logic [15:0]      r_accum;
  logic             r_overflow;
  logic             r_dropped;
  logic             r_oldest;
  logic             r_rdAvail;
  logic             r_rdBank;
  logic [WA_W:0]    r_rdLen;
  logic [7:0]       r_rdData;

  logic             w_fill;
  logic             w_room;
  logic             w_accept;
  logic [3:0]       w_shamt;
  logic [15:0]      w_word;
  logic             w_lastPix;
  logic             w_done;
  logic             w_memWe;
  logic [WA_W:0]    w_memAddr;
  logic [WA_W:0]    w_doneLen;
  logic             w_empty0;
  logic             w_empty1;
  logic             w_startOk;
  logic             w_startBank;
  logic             w_dropNow;
  logic             w_full0;
  logic             w_full1;
  logic             w_pick;
  logic [15:0]      w_rdWord;

  // A partial word is flushed on done, including a pixel accepted in the same cycle.
  always_comb begin
    w_fill      = (r_wrState == W_FILL);
    w_room      = (r_wordCnt < DEPTH_CNT);
    w_accept    = w_fill && bus.wr_pix_valid && w_room;
    w_shamt     = 4'(int'(r_pixIdx) * PIX_W);
    w_word      = r_accum | (w_accept ? (16'(bus.wr_pix) << w_shamt) : 16'h0000);
    w_lastPix   = (r_pixIdx == IDX_W'(PPW-1));
    w_done      = w_fill && bus.wr_frame_done;
    w_memWe     = (w_accept && w_lastPix) ||
                  (w_done && w_room && (w_accept || (r_pixIdx != '0)));
    w_memAddr   = {r_wrBank, r_wordCnt[WA_W-1:0]};
    w_doneLen   = r_wordCnt + {{WA_W{1'b0}}, w_memWe};
    w_empty0    = (r_bankState[0] == B_EMPTY);
    w_empty1    = (r_bankState[1] == B_EMPTY);
    w_startOk   = bus.wr_frame_start && !w_fill && (w_empty0 || w_empty1);
    w_startBank = !w_empty0;
    w_dropNow   = bus.wr_frame_start && !w_fill && !w_empty0 && !w_empty1;
    w_full0     = (r_bankState[0] == B_FULL);
    w_full1     = (r_bankState[1] == B_FULL);
    w_pick      = (w_full0 && w_full1) ? r_oldest : w_full1;
    w_rdWord    = r_mem[{r_rdBank, bus.rd_addr[RA_W-1:1]}];
  end

  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_memAddr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bankState[0] <= B_EMPTY;
      r_bankState[1] <= B_EMPTY;
      r_bankLen[0]   <= '0;
      r_bankLen[1]   <= '0;
      r_wrState      <= W_IDLE;
      r_wrBank       <= 1'b0;
      r_wordCnt      <= '0;
      r_pixIdx       <= '0;
      r_accum        <= 16'h0000;
      r_overflow     <= 1'b0;
      r_dropped      <= 1'b0;
      r_oldest       <= 1'b0;
      r_rdAvail      <= 1'b0;
      r_rdBank       <= 1'b0;
      r_rdLen        <= '0;
      r_rdData       <= 8'h00;
    end else begin
      r_dropped <= 1'b0;
      if (w_fill) begin
        if (w_done) begin
          r_wrState          <= W_IDLE;
          r_bankLen[r_wrBank] <= w_doneLen;
          if (w_doneLen == '0) begin
            r_bankState[r_wrBank] <= B_EMPTY;
          end else begin
            r_bankState[r_wrBank] <= B_FULL;
            if (r_bankState[~r_wrBank] != B_FULL) r_oldest <= r_wrBank;
          end
        end else if (w_accept) begin
          if (w_lastPix) begin
            r_accum   <= 16'h0000;
            r_pixIdx  <= '0;
            r_wordCnt <= r_wordCnt + 1'b1;
          end else begin
            r_accum  <= w_word;
            r_pixIdx <= r_pixIdx + IDX_W'(1);
          end
        end
        if (bus.wr_pix_valid && !w_room) r_overflow <= 1'b1;
      end else if (w_startOk) begin
        r_wrState                <= W_FILL;
        r_wrBank                 <= w_startBank;
        r_bankState[w_startBank] <= B_FILLING;
        r_wordCnt                <= '0;
        r_pixIdx                 <= '0;
        r_accum                  <= 16'h0000;
        r_overflow               <= 1'b0;
      end else if (w_dropNow) begin
        r_wrState <= W_DROP;
        r_dropped <= 1'b1;
      end else if (r_wrState == W_DROP && bus.wr_frame_done) begin
        r_wrState <= W_IDLE;
      end

      // Presentation only considers banks already FULL before this edge.
      if (r_rdAvail) begin
        if (bus.rd_release) begin
          r_bankState[r_rdBank] <= B_EMPTY;
          r_rdAvail             <= 1'b0;
          r_rdLen               <= '0;
        end
      end else if (w_full0 || w_full1) begin
        r_bankState[w_pick] <= B_READING;
        r_rdBank            <= w_pick;
        r_rdAvail           <= 1'b1;
        r_rdLen             <= r_bankLen[w_pick];
      end

      if (r_rdAvail) r_rdData <= bus.rd_addr[0] ? w_rdWord[15:8] : w_rdWord[7:0];
      else           r_rdData <= 8'h00;
    end
  end

`ifdef PPBUF_DROP_CNT_EN
  logic [7:0] r_dropCnt;

  always_ff @(posedge clk) begin
    if (reset)                              r_dropCnt <= 8'd0;
    else if (w_dropNow && r_dropCnt != 8'hFF) r_dropCnt <= r_dropCnt + 8'd1;
  end

  assign bus.drop_count = r_dropCnt;
`else
  assign bus.drop_count = 8'd0;
`endif

  assign bus.rd_data        = r_rdData;
  assign bus.rd_frame_avail = r_rdAvail;
  assign bus.rd_frame_len   = r_rdLen;
  assign bus.wr_busy        = (r_wrState == W_FILL);
  assign bus.frame_dropped  = r_dropped;
  assign bus.overflow       = r_overflow;
endmodule

// File: doc/pingpong_frame_buffer.md
PINGPONG_FRAME_BUFFER -- requirements
Module: pingpong_frame_buffer

Interface
REQ-001 Parameter PIX_W, default 1, bits per pixel; legal values 1, 2, 4, 8.
REQ-002 Parameter DEPTH, default 16384, 16-bit words per bank; power of two.
REQ-003 Derived widths: WA_W = log2(DEPTH); RA_W = WA_W+1 (byte address).
REQ-004 Port clk, in, 1: sole clock, all logic on rising edge.
REQ-005 Port reset, in, 1: synchronous, active-high reset.
REQ-006 Port wr_frame_start, in, 1: writer requests a bank for a new frame.
REQ-007 Port wr_pix_valid, in, 1: wr_pix valid this cycle.
REQ-008 Port wr_pix, in, PIX_W: pixel value.
REQ-009 Port wr_frame_done, in, 1: frame complete; flush and commit.
REQ-010 Port rd_addr, in, RA_W: byte address into the presented frame.
REQ-011 Port rd_data, out, 8: registered read byte.
REQ-012 Port rd_frame_avail, out, 1: a committed frame is presented to the reader.
REQ-013 Port rd_frame_len, out, WA_W+1: word count of the presented frame.
REQ-014 Port rd_release, in, 1: reader finished; presented bank freed.
REQ-015 Port wr_busy, out, 1: a bank is being filled.
REQ-016 Port frame_dropped, out, 1: one-cycle pulse, frame start refused.
REQ-017 Port overflow, out, 1: sticky until next accepted frame start; pixels exceeded bank.
REQ-018 Port drop_count, out, 8: saturating count of refused frames.

Function
REQ-019 Two banks of DEPTH x 16 bits, each with state EMPTY, FILLING, FULL or READING.
REQ-020 wr_frame_start with wr_busy=0 and an EMPTY bank: that bank -> FILLING; bank 0 preferred if both EMPTY; word and pixel counters cleared.
REQ-021 wr_frame_start with no EMPTY bank: frame_dropped pulses next cycle, drop_count increments (saturates at 255), pixels of that frame discarded.
REQ-022 wr_frame_start while wr_busy=1 is ignored.
REQ-023 Pixels pack LSB-first: pixel k of a word occupies bits [k*PIX_W +: PIX_W]; 16/PIX_W pixels per word.
REQ-024 Word written on the cycle its last pixel is accepted; word address increments by one.
REQ-025 wr_frame_done: partial word flushed with unused bits zero, bank -> FULL, length latched, wr_busy drops next cycle.
REQ-026 wr_frame_done with zero pixels written: bank -> EMPTY, nothing presented.
REQ-027 Pixels after DEPTH words are written are discarded and overflow set; length saturates at DEPTH.
REQ-028 wr_pix_valid or wr_frame_done while not filling or while dropping: ignored (done ends a drop).
REQ-029 Reader idle and a FULL bank exists: oldest FULL bank -> READING, rd_frame_avail=1 the following cycle.
REQ-030 rd_release while READING: bank -> EMPTY, rd_frame_avail=0 next cycle; ignored otherwise.
REQ-031 rd_data = byte rd_addr[0] (0 = bits[7:0]) of word rd_addr[RA_W-1:1] of the READING bank, one cycle latency; 0x00 when no bank READING.
REQ-032 Same-cycle wr_frame_done and rd_release both take effect; the newly FULL bank is presented no earlier than the cycle after release.
REQ-033 Same-cycle rd_release and wr_frame_start: start sees only banks EMPTY before that edge.
REQ-034 Writer never writes a READING or FULL bank; reader never sees a FILLING bank.

Reset
REQ-035 On reset: both banks EMPTY, all counters 0, rd_data=0x00, rd_frame_avail=0, rd_frame_len=0, wr_busy=0, frame_dropped=0, overflow=0, drop_count=0.
REQ-036 Reset mid-frame discards all bank contents logically; memory array contents are not cleared.

Configuration
REQ-037 Macro PPBUF_DROP_CNT_EN defined: drop_count behaves per REQ-021.
REQ-038 Macro PPBUF_DROP_CNT_EN undefined: counter not built, drop_count tied to 0; frame_dropped and all other behaviour unchanged.

Verification
REQ-039 PIX_W=1: start, 32 pixels alternating 1,0, done -> rd_frame_avail=1, rd_frame_len=2, rd_addr 0..3 read 0x55 each.
REQ-040 PIX_W=4: start, 5 pixels 1..5, done -> rd_frame_len=2, bytes 0x21,0x43,0x05,0x00.
REQ-041 Two frames committed, no release, third start -> frame_dropped one pulse, drop_count=1; release then start -> accepted, wr_busy=1.
REQ-042 DEPTH=4, PIX_W=8: 10 pixels -> overflow=1, rd_frame_len=4, bytes 0..7 = first 8 pixels.
REQ-043 Same-cycle wr_frame_done (bank B) and rd_release (bank A) -> A EMPTY, B presented next cycle, rd_data from B.
REQ-044 reset asserted mid-frame with a frame READING -> all outputs at REQ-035 values next cycle; subsequent frame uses bank 0.
